// File: rtl/aes_pkg.sv
// Shared AES definitions: round constants, FSM encoding, GF(2^8) doubling and byte/column indexing.
package aes_pkg;

   localparam int unsigned BLK_W      = 128;
   localparam int unsigned WORD_W     = 32;
   localparam int unsigned BYTE_W     = 8;
   localparam int unsigned NB         = 4;
   localparam int unsigned NUM_ROUNDS = 10;
   localparam int unsigned DONE_ENC   = 11;

   localparam logic [BYTE_W-1:0] RCON_INIT = 8'h01;
   localparam logic [BYTE_W-1:0] RCON_LAST = 8'h36;

   typedef enum logic [3:0] {
      ST_IDLE  = 4'd0,
      ST_R1    = 4'd1,
      ST_R2    = 4'd2,
      ST_R3    = 4'd3,
      ST_R4    = 4'd4,
      ST_R5    = 4'd5,
      ST_R6    = 4'd6,
      ST_R7    = 4'd7,
      ST_R8    = 4'd8,
      ST_R9    = 4'd9,
      ST_FINAL = 4'(NUM_ROUNDS),
      ST_DONE  = 4'(DONE_ENC)
   } fsm_e;

   function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Column c occupies bits [32c+31:32c]; row 0 sits in the column's top byte.
   function automatic int unsigned col_lsb(input int unsigned c);
      return WORD_W * c;
   endfunction

   function automatic int unsigned byte_lsb(input int unsigned r, input int unsigned c);
      return WORD_W * c + BYTE_W * (NB - 1 - r);
   endfunction

endpackage

// File: rtl/aes_key_shedualing.sv
// Forward AES-128 key expansion step: one round key and the following rcon.
module aes_key_shedualing
   import aes_pkg::*;
(
   input  logic [127:0] key,
   input  logic [7:0]   rcon,
   output logic [127:0] key_next,
   output logic [7:0]   rcon_next
);

   logic [31:0] w0, w1, w2, w3;
   logic [31:0] rot_w, sub_w, tmp_w;
   logic [31:0] n0, n1, n2, n3;

   assign {w0, w1, w2, w3} = key;
   assign rot_w = {w3[23:0], w3[31:24]};

   for (genvar i = 0; i < 4; i++) begin : g_sub
      aes_sbox u_sbox (
         .din  (rot_w[8*i +: 8]),
         .dout (sub_w[8*i +: 8])
      );
   end

   assign tmp_w = sub_w ^ {rcon, 24'h000000};
   assign n0 = w0 ^ tmp_w;
   assign n1 = w1 ^ n0;
   assign n2 = w2 ^ n1;
   assign n3 = w3 ^ n2;

   assign key_next  = {n0, n1, n2, n3};
   assign rcon_next = xtime(rcon);

endmodule

// File: rtl/aes_mixw.sv
// MixColumns on a single 32-bit column, row 0 in the top byte.
module aes_mixw
   import aes_pkg::*;
(
   input  logic [31:0] col,
   output logic [31:0] mixed
);

   logic [7:0] a0, a1, a2, a3;

   assign {a0, a1, a2, a3} = col;

   assign mixed[31:24] = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
   assign mixed[23:16] = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
   assign mixed[15:8]  = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
   assign mixed[7:0]   = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);

endmodule

// File: rtl/aes_sbox.sv
// AES forward S-box, purely combinational table lookup.
module aes_sbox (
   input  logic [7:0] din,
   output logic [7:0] dout
);

   // Entry 0x00 is the most significant byte of the table.
   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   assign dout = SBOX_TBL[{~din, 3'b000} +: 8];

endmodule

// File: rtl/aes_enc.sv
// Iterative AES-128 encryptor, one round per clock with ready/valid input and a one-cycle result strobe.
// Define AES_ENC_KEY_OUT_EN to expose round key 10 on key_last_o for the decryptor.
module aes_enc
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         nreset,
   input  logic         data_v_i,
   input  logic [127:0] data_i,
   input  logic [127:0] key_i,
   output logic         ready_o,
   output logic         res_v_o,
`ifdef AES_ENC_KEY_OUT_EN
   output logic [127:0] res_o,
   output logic [127:0] key_last_o
`else
   output logic [127:0] res_o
`endif
);

   fsm_e               fsm_q, fsm_d;
   logic [BLK_W-1:0]   data_q, data_d;
   logic [BLK_W-1:0]   key_q, key_d;
   logic [BYTE_W-1:0]  rcon_q, rcon_d;

   logic               accept;
   logic [BLK_W-1:0]   sb_w, sr_w, mc_w;
   logic [BLK_W-1:0]   ks_key_in, ks_key_out;
   logic [BYTE_W-1:0]  ks_rcon_in, ks_rcon_out;

   // SubBytes followed by the encrypt-direction row rotation.
   for (genvar r = 0; r < 4; r++) begin : g_row
      for (genvar c = 0; c < 4; c++) begin : g_col
         aes_sbox u_sbox (
            .din  (data_q[byte_lsb(r, c) +: 8]),
            .dout (sb_w[byte_lsb(r, c) +: 8])
         );
         assign sr_w[byte_lsb(r, c) +: 8] = sb_w[byte_lsb(r, (c + 4 - r) % 4) +: 8];
      end
   end

   for (genvar c = 0; c < 4; c++) begin : g_mix
      aes_mixw u_mixw (
         .col   (sr_w[col_lsb(c) +: 32]),
         .mixed (mc_w[col_lsb(c) +: 32])
      );
   end

   // A new block expands from the raw cipher key; otherwise the schedule advances from key_q.
   assign ks_key_in  = accept ? key_i : key_q;
   assign ks_rcon_in = accept ? RCON_INIT : rcon_q;

   aes_key_shedualing u_key_shedualing (
      .key       (ks_key_in),
      .rcon      (ks_rcon_in),
      .key_next  (ks_key_out),
      .rcon_next (ks_rcon_out)
   );

   assign ready_o = (fsm_q == ST_IDLE) | (fsm_q == ST_DONE);
   assign res_v_o = (fsm_q == ST_DONE);
   assign res_o   = data_q;
   assign accept  = data_v_i & ready_o;
`ifdef AES_ENC_KEY_OUT_EN
   assign key_last_o = key_q;
`endif

   always_ff @(posedge clk) begin
      if (!nreset) begin
         fsm_q  <= ST_IDLE;
         data_q <= '0;
         key_q  <= '0;
         rcon_q <= '0;
      end else begin
         fsm_q  <= fsm_d;
         data_q <= data_d;
         key_q  <= key_d;
         rcon_q <= rcon_d;
      end
   end

   always_comb begin
      fsm_d  = fsm_q;
      data_d = data_q;
      key_d  = key_q;
      rcon_d = rcon_q;
      if (accept) begin
         data_d = data_i ^ key_i;
         key_d  = ks_key_out;
         rcon_d = ks_rcon_out;
         fsm_d  = ST_R1;
      end else begin
         unique case (fsm_q)
            ST_IDLE: ;
            ST_R1, ST_R2, ST_R3, ST_R4, ST_R5, ST_R6, ST_R7, ST_R8, ST_R9: begin
               data_d = mc_w ^ key_q;
               key_d  = ks_key_out;
               rcon_d = ks_rcon_out;
               fsm_d  = fsm_e'(fsm_q + 4'd1);
            end
            ST_FINAL: begin
               data_d = sr_w ^ key_q;
               fsm_d  = ST_DONE;
            end
            ST_DONE: fsm_d = ST_IDLE;
            default: fsm_d = ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_enc.sv
// Scoreboard bench for aes_enc using FIPS-197 vectors; key_last_o is checked when AES_ENC_KEY_OUT_EN is defined.
module tb_aes_enc;

   logic         clk = 1'b0;
   logic         nreset = 1'b0;
   logic         data_v_i = 1'b0;
   logic [127:0] data_i = '0;
   logic [127:0] key_i = '0;
   logic         ready_o;
   logic         res_v_o;
   logic [127:0] res_o;
`ifdef AES_ENC_KEY_OUT_EN
   logic [127:0] key_last_o;
`endif

   aes_enc dut (
      .clk        (clk),
      .nreset     (nreset),
      .data_v_i   (data_v_i),
      .data_i     (data_i),
      .key_i      (key_i),
      .ready_o    (ready_o),
      .res_v_o    (res_v_o),
`ifdef AES_ENC_KEY_OUT_EN
      .res_o      (res_o),
      .key_last_o (key_last_o)
`else
      .res_o      (res_o)
`endif
   );

   always #5 clk = ~clk;

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C1_KL  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] B_KL   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

   typedef struct {
      logic [127:0] ct;
      logic [127:0] kl;
      int unsigned  cyc;
      string        name;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          failures = 0;
   int unsigned cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Monitor: every result strobe must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (nreset === 1'b1 && res_v_o === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_result: got res_v_o=1 with res_o=%h expected no result", res_o);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk({e.name, "_ct"}, res_o, e.ct);
            chk({e.name, "_latency_cycle"}, 128'(cyc), 128'(e.cyc));
            chk({e.name, "_ready_in_done"}, 128'(ready_o), 128'd1);
`ifdef AES_ENC_KEY_OUT_EN
            chk({e.name, "_key_last"}, key_last_o, e.kl);
`endif
         end
      end
   end

   // Present a block and hold it until accepted; data_v_i stays high on return.
   task automatic send(input logic [127:0] pt, input logic [127:0] key,
                       input logic [127:0] ct, input logic [127:0] kl, input string nm);
      int n;
      @(negedge clk);
      data_v_i = 1'b1;
      data_i   = pt;
      key_i    = key;
      n = 0;
      while (ready_o !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         checks++;
         failures++;
         $display("FAIL %s_accept_timeout: got ready_o=%b expected 1 within 200 cycles", nm, ready_o);
      end else begin
         sb.push_back('{ct: ct, kl: kl, cyc: cyc + 11, name: nm});
      end
      @(posedge clk);
   endtask

   task automatic wait_drain(input string nm);
      int n;
      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         checks++;
         failures++;
         $display("FAIL %s_drain_timeout: got %0d pending expected 0", nm, sb.size());
         sb.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      // Reset state
      nreset = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_ready", 128'(ready_o), 128'd1);
      chk("reset_res_v", 128'(res_v_o), 128'd0);
      chk("reset_res", res_o, '0);
`ifdef AES_ENC_KEY_OUT_EN
      chk("reset_key_last", key_last_o, '0);
`endif
      nreset = 1'b1;

      // Single blocks
      send(C1_PT, C1_KEY, C1_CT, C1_KL, "c1");
      @(negedge clk);
      data_v_i = 1'b0;
      wait_drain("c1");
      repeat (3) @(negedge clk);
      chk("idle_hold_res", res_o, C1_CT);
      chk("idle_ready", 128'(ready_o), 128'd1);

      send(B_PT, B_KEY, B_CT, B_KL, "appb");
      @(negedge clk);
      data_v_i = 1'b0;
      wait_drain("appb");

      // Offers during rounds 3..10 must be ignored
      send(C1_PT, C1_KEY, C1_CT, C1_KL, "busy");
      @(negedge clk);
      data_v_i = 1'b0;
      repeat (2) @(negedge clk);
      data_v_i = 1'b1;
      data_i   = 128'hffeeddccbbaa99887766554433221100;
      key_i    = 128'ha5a5a5a55a5a5a5a0f0f0f0ff0f0f0f0;
      for (int i = 0; i < 7; i++) begin
         chk($sformatf("busy_ready_r%0d", i + 3), 128'(ready_o), 128'd0);
         @(negedge clk);
      end
      chk("busy_ready_r10", 128'(ready_o), 128'd0);
      data_v_i = 1'b0;
      wait_drain("busy");

      // Back-to-back with data_v_i held high
      send(C1_PT, C1_KEY, C1_CT, C1_KL, "b2b_c1");
      send(B_PT, B_KEY, B_CT, B_KL, "b2b_appb");
      @(negedge clk);
      data_v_i = 1'b0;
      wait_drain("b2b");

      // Reset during round 5 discards the block
      send(B_PT, B_KEY, B_CT, B_KL, "abort");
      @(negedge clk);
      data_v_i = 1'b0;
      repeat (4) @(negedge clk);
      nreset = 1'b0;
      @(negedge clk);
      sb.delete();
      chk("abort_ready", 128'(ready_o), 128'd1);
      chk("abort_res_v", 128'(res_v_o), 128'd0);
      chk("abort_res", res_o, '0);
`ifdef AES_ENC_KEY_OUT_EN
      chk("abort_key_last", key_last_o, '0);
`endif
      nreset = 1'b1;
      repeat (15) @(negedge clk);
      chk("abort_res_after", res_o, '0);

      // Encryption after the abort still works
      send(B_PT, B_KEY, B_CT, B_KL, "post_abort");
      @(negedge clk);
      data_v_i = 1'b0;
      wait_drain("post_abort");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
